// File: rtl/step_incrementer.sv
// step_incrementer: emits count_i values from a base, stepping the field at bit LSB_IDX and above.
// Define STEP_INCREMENTER_SAT_EN to make the stepped field saturate instead of wrapping.
module step_incrementer #(
  parameter int WIDTH      = 8,
  parameter int POWER_OF_2 = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_data_i,
  input  logic [WIDTH-1:0] count_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wrap_o
);

  localparam int LSB_IDX = 1 << POWER_OF_2;
  localparam int FW      = WIDTH - LSB_IDX;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [FW-1:0]    field;
  logic [FW:0]      field_inc;
`ifdef STEP_INCREMENTER_SAT_EN
  // Set after the first overflow so later overflow attempts stay silent.
  logic             sat_q, sat_d;
`endif

  assign field     = data_q[WIDTH-1:LSB_IDX];
  assign field_inc = {1'b0, field} + (FW+1)'(1);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
`ifdef STEP_INCREMENTER_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d      = start_data_i;
          remaining_d = count_i;
`ifdef STEP_INCREMENTER_SAT_EN
          sat_d       = 1'b0;
`endif
          if (count_i != '0) state_d = RUN;
          else               done_d  = 1'b1;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (remaining_q == WIDTH'(1)) begin
            state_d     = IDLE;
            remaining_d = '0;
            done_d      = 1'b1;
          end else begin
            remaining_d = remaining_q - WIDTH'(1);
            data_d[WIDTH-1:LSB_IDX] = field_inc[FW-1:0];
            if (field_inc[FW]) begin
`ifdef STEP_INCREMENTER_SAT_EN
              data_d[WIDTH-1:LSB_IDX] = '1;
              wrap_d = !sat_q;
              sat_d  = 1'b1;
`else
              wrap_d = 1'b1;
`endif
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
`ifdef STEP_INCREMENTER_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
`ifdef STEP_INCREMENTER_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == RUN);
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_step_incrementer.sv
// Bench for step_incrementer (WIDTH=8, POWER_OF_2=0 -> step 2, bit 0 passes through).
module tb_step_incrementer;

  logic       clk_i = 1'b0;
  logic       rst_ni, start_i, ready_i;
  logic [7:0] start_data_i, count_i, data_o;
  logic       valid_o, busy_o, done_o, wrap_o;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];  // {wrap, data} per expected accepted beat

  typedef struct {
    logic [7:0]      base;
    logic [7:0]      cnt;
    logic [4:0][7:0] d;  // d[0] is first value
    logic [4:0]      w;  // expected wrap_o alongside d[i]
  } vec_t;
  vec_t vecs[6];

  always #5 clk_i = ~clk_i;

  step_incrementer #(.WIDTH(8), .POWER_OF_2(0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .start_data_i(start_data_i),
    .count_i(count_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every beat that will be accepted at the next edge is compared here.
  always @(negedge clk_i) begin
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", data_o);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("beat_data", {24'b0, data_o}, {24'b0, e[7:0]});
        check("beat_wrap", {31'b0, wrap_o}, {31'b0, e[8]});
      end
    end
  end

  task automatic run_seq(input logic [7:0] base, input logic [7:0] cnt, input bit glitch);
    int cyc;
    bit busy_seen, valid_seen;
    @(posedge clk_i); #1;
    start_i = 1'b1; start_data_i = base; count_i = cnt; ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = glitch; start_data_i = 8'hAA; count_i = 8'd7;
    cyc = 0; busy_seen = 0; valid_seen = 0;
    if (glitch) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
      cyc = 1; busy_seen = 1; valid_seen = 1;
    end
    do begin
      @(negedge clk_i);
      cyc++;
      if (busy_o) busy_seen = 1;
      if (valid_o) valid_seen = 1;
    end while (!done_o && cyc < 40);
    check("done_latency", cyc, cnt + 1);
    check("busy_seen", {31'b0, busy_seen}, {31'b0, cnt != 0});
    check("valid_seen", {31'b0, valid_seen}, {31'b0, cnt != 0});
    check("valid_at_done", {31'b0, valid_o}, 0);
    check("busy_at_done", {31'b0, busy_o}, 0);
    @(negedge clk_i);
    check("done_one_pulse", {31'b0, done_o}, 0);
    check("wrap_idle", {31'b0, wrap_o}, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    bit done_seen;
    vecs[0] = '{base: 8'h10, cnt: 8'd3, d: {8'h00, 8'h00, 8'h14, 8'h12, 8'h10}, w: 5'b00000};
    vecs[1] = '{base: 8'h13, cnt: 8'd2, d: {8'h00, 8'h00, 8'h00, 8'h15, 8'h13}, w: 5'b00000};
`ifdef STEP_INCREMENTER_SAT_EN
    vecs[2] = '{base: 8'hFE, cnt: 8'd3, d: {8'h00, 8'h00, 8'hFE, 8'hFE, 8'hFE}, w: 5'b00010};
    vecs[4] = '{base: 8'hFD, cnt: 8'd4, d: {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFD}, w: 5'b00100};
`else
    vecs[2] = '{base: 8'hFE, cnt: 8'd3, d: {8'h00, 8'h00, 8'h02, 8'h00, 8'hFE}, w: 5'b00010};
    vecs[4] = '{base: 8'hFD, cnt: 8'd4, d: {8'h00, 8'h03, 8'h01, 8'hFF, 8'hFD}, w: 5'b00100};
`endif
    vecs[3] = '{base: 8'h00, cnt: 8'd0, d: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, w: 5'b00000};
    vecs[5] = '{base: 8'h05, cnt: 8'd5, d: {8'h0D, 8'h0B, 8'h09, 8'h07, 8'h05}, w: 5'b00000};

    rst_ni = 1'b0; start_i = 1'b0; ready_i = 1'b0; start_data_i = 8'h00; count_i = 8'h00;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_data", {24'b0, data_o}, 0);
    check("rst_valid", {31'b0, valid_o}, 0);
    check("rst_busy", {31'b0, busy_o}, 0);
    check("rst_done", {31'b0, done_o}, 0);
    check("rst_wrap", {31'b0, wrap_o}, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].cnt; j++) exp_q.push_back({vecs[i].w[j], vecs[i].d[j]});
      run_seq(vecs[i].base, vecs[i].cnt, i == 1);
    end

    // Backpressure: value and valid must hold while ready_i is low.
    exp_q.push_back({1'b0, 8'h40});
    exp_q.push_back({1'b0, 8'h42});
    @(posedge clk_i); #1;
    start_i = 1'b1; start_data_i = 8'h40; count_i = 8'd2; ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("bp_data", {24'b0, data_o}, 32'h40);
      check("bp_valid", {31'b0, valid_o}, 1);
      check("bp_busy", {31'b0, busy_o}, 1);
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk_i);
      cyc++;
    end while (!done_o && cyc < 40);
    check("bp_done_latency", cyc, 3);
    check("bp_queue_drained", exp_q.size(), 0);

    // Mid-run reset while the second of five values is on the bus.
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b0, 8'h32});
    @(posedge clk_i); #1;
    start_i = 1'b1; start_data_i = 8'h30; count_i = 8'd5; ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("mrst_data", {24'b0, data_o}, 0);
    check("mrst_valid", {31'b0, valid_o}, 0);
    check("mrst_busy", {31'b0, busy_o}, 0);
    check("mrst_done", {31'b0, done_o}, 0);
    check("mrst_wrap", {31'b0, wrap_o}, 0);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (done_o) done_seen = 1;
    end
    check("mrst_no_done", {31'b0, done_seen}, 0);
    check("mrst_queue_drained", exp_q.size(), 0);
    exp_q.push_back({1'b0, 8'h20});
    run_seq(8'h20, 8'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
